// File: rtl/nios2test_nios2_gen2_0_cpu_debug_mem_port.sv
// Debug-memory access stage: JTAG monitor commands and a CPU Avalon-MM slave share one debug RAM.
// Optional write protection of CPU writes outside debug mode: define DEBUG_MEM_CPU_WP_EN.
module nios2test_nios2_gen2_0_cpu_debug_mem_port #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
`ifdef DEBUG_MEM_CPU_WP_EN
  ,
  input  logic              debugack
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       jtag_q;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              busy;
  logic              jtag_rd_pend;
  logic              cpu_rd_pend;

  logic              any_cmd, multi_cmd, accept;
  logic              sel_a, sel_n, sel_b;
  logic              jtag_rd, jtag_wr, jtag_access;
  logic [ADDR_W-1:0] jdo_addr, jtag_addr;
  logic              cpu_rd_req, cpu_rd_go, cpu_wr_go, cpu_wr_allowed;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic              err_set;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37], jdo[2:0]};

`ifdef DEBUG_MEM_CPU_WP_EN
  assign cpu_wr_allowed = debugack;
`else
  assign cpu_wr_allowed = 1'b1;
`endif

  assign monitor_ready = ~busy;

  always_comb begin
    any_cmd   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    multi_cmd = (take_action_ocimem_b & take_action_ocimem_a)
              | (take_action_ocimem_b & take_no_action_ocimem_a)
              | (take_action_ocimem_a & take_no_action_ocimem_a);
    accept    = any_cmd & ~busy & ~reset;

    // ocimem_b outranks ocimem_a, which outranks no_action_a
    sel_b = accept & take_action_ocimem_b;
    sel_a = accept & take_action_ocimem_a & ~take_action_ocimem_b;
    sel_n = accept & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    jdo_addr    = jdo[17+ADDR_W-1:17];
    jtag_rd     = (sel_a & jdo[35]) | sel_n;
    jtag_wr     = sel_b;
    jtag_access = jtag_rd | jtag_wr;
    jtag_addr   = sel_a ? jdo_addr : mon_a_reg;

    // a simultaneous read+write request is serviced as a write
    cpu_rd_req = cpu_read & ~cpu_write;
    cpu_rd_go  = cpu_rd_req & ~cpu_rd_pend & ~jtag_access & ~reset;
    cpu_wr_go  = cpu_write & ~jtag_access & ~reset;
    cpu_waitrequest = cpu_write ? jtag_access : (cpu_rd_req & ~cpu_rd_pend);

    ram_we    = 1'b0;
    ram_waddr = mon_a_reg;
    ram_wdata = jdo[34:3];
    if (jtag_wr) begin
      ram_we = 1'b1;
    end else if (cpu_wr_go && cpu_wr_allowed) begin
      ram_we    = 1'b1;
      ram_waddr = cpu_address;
      ram_wdata = cpu_writedata;
    end

    err_set = (any_cmd & busy)
            | (accept & multi_cmd)
            | (cpu_read & cpu_write)
            | (cpu_wr_go & ~cpu_wr_allowed);
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (jtag_rd) jtag_q <= mem[jtag_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_reg     <= RESET_ADDR;
      busy          <= 1'b0;
      jtag_rd_pend  <= 1'b0;
      cpu_rd_pend   <= 1'b0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
      cpu_readdata  <= '0;
    end else begin
      busy         <= accept;
      jtag_rd_pend <= jtag_rd;
      cpu_rd_pend  <= cpu_rd_go;
      if (jtag_rd_pend) MonDReg <= jtag_q;
      if (cpu_rd_go) cpu_readdata <= mem[cpu_address];

      if (sel_a) mon_a_reg <= jdo_addr;
      else if (sel_b || sel_n) mon_a_reg <= mon_a_reg + 1'b1;

      // a new error in the same cycle beats a clear request
      if (err_set) monitor_error <= 1'b1;
      else if (sel_a && jdo[36]) monitor_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2test_nios2_gen2_0_cpu_debug_mem_port.sv
// Scoreboard bench for the debug-memory port: a word-array model predicts MonDReg,
// monitor_error and cpu_readdata; a negedge monitor pops and compares.
module tb_nios2test_nios2_gen2_0_cpu_debug_mem_port;
  localparam int ADDR_W = 8;

  logic        clk = 0, reset = 1;
  logic [37:0] jdo = '0;
  logic        ta_a = 0, tn_a = 0, ta_b = 0;
  logic [31:0] mon_d;
  logic        mon_rdy, mon_err;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 0, cpu_write = 0;
  logic [31:0] cpu_writedata = '0, cpu_readdata;
  logic        cpu_waitrequest;
  logic        debugack = 1;

  int tests = 0, fails = 0;

  typedef struct packed { logic [31:0] d; logic e; } jexp_t;
  jexp_t       jq[$];
  logic [31:0] cq[$];
  jexp_t       je;
  logic [31:0] ce;

  logic [31:0] m_mem [256];
  logic [7:0]  m_a = 0;
  logic [31:0] m_d = 0;
  logic        m_e = 0;
  logic        prev_rdy = 1;

  always #5 clk = ~clk;

  nios2test_nios2_gen2_0_cpu_debug_mem_port #(.ADDR_W(ADDR_W), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tn_a), .take_action_ocimem_b(ta_b),
    .MonDReg(mon_d), .monitor_ready(mon_rdy), .monitor_error(mon_err),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest)
`ifdef DEBUG_MEM_CPU_WP_EN
    , .debugack(debugack)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: JTAG result appears when monitor_ready rises; CPU read data when waitrequest drops
  always @(negedge clk) begin
    if (reset) prev_rdy = 1;
    else begin
      if (mon_rdy && !prev_rdy) begin
        if (jq.size() == 0) begin
          tests++; fails++;
          $display("FAIL jtag_unexpected_completion: got MonDReg %h with empty queue", mon_d);
        end else begin
          je = jq.pop_front();
          chk("MonDReg", mon_d, je.d);
          chk("monitor_error", {31'b0, mon_err}, {31'b0, je.e});
        end
      end
      prev_rdy = mon_rdy;
      if (cpu_read && !cpu_write && !cpu_waitrequest) begin
        if (cq.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_unexpected_read: got %h with empty queue", cpu_readdata);
        end else begin
          ce = cq.pop_front();
          chk("cpu_readdata", cpu_readdata, ce);
        end
      end
    end
  end

  function automatic logic [37:0] mk_jdo(input int kind, input logic rd, input logic clr,
                                         input logic [7:0] addr, input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    if (kind == 2 || kind == 3) j[34:3] = data;
    else j[24:17] = addr;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!mon_rdy && n < 20) begin n++; @(negedge clk); end
    if (!mon_rdy) begin
      tests++; fails++;
      $display("FAIL jtag_ready_timeout: monitor_ready got 0 expected 1");
    end
  endtask

  // kind: 0 ocimem_a, 1 no_action_a, 2 ocimem_b, 3 ocimem_b+ocimem_a, 4 ocimem_a+no_action_a
  task automatic jtag_cmd(input int kind, input logic rd, input logic clr,
                          input logic [7:0] addr, input logic [31:0] data);
    wait_ready();
    @(posedge clk); #1;
    jdo  = mk_jdo(kind, rd, clr, addr, data);
    ta_a = (kind == 0 || kind == 3 || kind == 4);
    tn_a = (kind == 1 || kind == 4);
    ta_b = (kind == 2 || kind == 3);
    case (kind)
      0, 4: begin
        m_a = addr;
        if (clr) m_e = 0;
        if (rd) m_d = m_mem[addr];
        if (kind == 4) m_e = 1;
      end
      1: begin m_d = m_mem[m_a]; m_a++; end
      default: begin
        m_mem[m_a] = jdo[34:3]; m_a++;
        if (kind == 3) m_e = 1;
      end
    endcase
    jq.push_back('{d: m_d, e: m_e});
    @(posedge clk); #1;
    ta_a = 0; tn_a = 0; ta_b = 0;
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic both);
    int n = 0;
    @(posedge clk); #1;
    cpu_address = addr; cpu_writedata = data; cpu_write = 1; cpu_read = both;
    @(negedge clk);
    while (cpu_waitrequest && n < 20) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    cpu_write = 0; cpu_read = 0;
    if (both) m_e = 1;
    if (debugack) m_mem[addr] = data;
    else m_e = 1;
    chk("cpu_wr_waits", n, 0);
  endtask

  task automatic cpu_rd(input logic [7:0] addr, input logic jt, input int exp_waits);
    int n = 0;
    @(posedge clk); #1;
    cpu_address = addr; cpu_read = 1;
    if (jt) begin
      jdo = mk_jdo(0, 1, 0, addr, 0); ta_a = 1;
      m_a = addr; m_d = m_mem[addr];
      jq.push_back('{d: m_d, e: m_e});
    end
    cq.push_back(m_mem[addr]);
    @(negedge clk);
    while (cpu_waitrequest && n < 20) begin
      n++;
      @(posedge clk); #1; ta_a = 0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    cpu_read = 0; ta_a = 0;
    chk("cpu_rd_waits", n, exp_waits);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'b0, mon_rdy}, 1);
    chk("reset_MonDReg", mon_d, 0);
    chk("reset_error", {31'b0, mon_err}, 0);
    chk("reset_waitrequest", {31'b0, cpu_waitrequest}, 0);
    chk("reset_readdata", cpu_readdata, 0);

    for (int i = 0; i < 256; i++) cpu_wr(i[7:0], $urandom, 0);

    // write then read back through a fresh address load
    jtag_cmd(0, 0, 0, 8'h10, 0);
    jtag_cmd(2, 0, 0, 0, 32'hDEADBEEF);
    jtag_cmd(0, 1, 0, 8'h10, 0);

    // address wrap
    jtag_cmd(0, 0, 0, 8'hFF, 0);
    jtag_cmd(2, 0, 0, 0, 32'h1);
    jtag_cmd(2, 0, 0, 0, 32'h2);
    jtag_cmd(1, 0, 0, 0, 0);
    jtag_cmd(0, 1, 0, 8'hFF, 0);
    jtag_cmd(0, 1, 0, 8'h00, 0);

    // command while busy is dropped and flags an error
    wait_ready();
    @(posedge clk); #1;
    jdo = mk_jdo(2, 0, 0, 0, 32'hA5A5_0001); ta_b = 1;
    m_mem[m_a] = 32'hA5A5_0001; m_a++;
    @(posedge clk); #1;
    ta_b = 0; tn_a = 1; m_e = 1;
    jq.push_back('{d: m_d, e: m_e});
    @(posedge clk); #1;
    tn_a = 0;
    jtag_cmd(1, 0, 0, 0, 0);
    jtag_cmd(0, 0, 1, 8'h10, 0);

    // CPU read colliding with a JTAG read
    cpu_rd(8'h10, 1, 2);
    cpu_rd(8'h10, 0, 1);

    // simultaneous read+write is a write plus an error
    cpu_wr(8'h30, 32'h1234_5678, 1);
    jtag_cmd(0, 1, 0, 8'h30, 0);
    jtag_cmd(4, 1, 1, 8'h10, 0);
    jtag_cmd(0, 0, 1, 8'h00, 0);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: jtag_cmd(0, 1'($urandom), 1'($urandom), 8'($urandom), 0);
        1: jtag_cmd(1, 0, 0, 0, 0);
        2: jtag_cmd(2, 0, 0, 0, $urandom);
        3: cpu_wr(8'($urandom), $urandom, 0);
        4: cpu_rd(8'($urandom), 0, 1);
        5: jtag_cmd(3, 0, 0, 0, $urandom);
        default: jtag_cmd(4, 1'($urandom), 1'($urandom), 8'($urandom), 0);
      endcase
    end
    jtag_cmd(0, 0, 1, 8'h00, 0);

`ifdef DEBUG_MEM_CPU_WP_EN
    debugack = 0;
    cpu_wr(8'h20, 32'h55, 0);
    @(negedge clk);
    chk("wp_error", {31'b0, mon_err}, {31'b0, m_e});
    cpu_rd(8'h20, 0, 1);
    debugack = 1;
    cpu_wr(8'h20, 32'h55, 0);
    cpu_rd(8'h20, 0, 1);
    jtag_cmd(0, 1, 1, 8'h20, 0);
`endif

    // reset abandons a pending read and ignores a write pulse in the reset cycle
    wait_ready();
    @(posedge clk); #1;
    jdo = mk_jdo(0, 1, 0, 8'h10, 0); ta_a = 1;
    @(posedge clk); #1;
    ta_a = 0; reset = 1;
    jdo = mk_jdo(2, 0, 0, 0, 32'hCAFE_F00D); ta_b = 1;
    @(posedge clk); #1;
    reset = 0; ta_b = 0;
    m_a = 0; m_d = 0; m_e = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_MonDReg", mon_d, m_d);
    chk("rst_mid_ready", {31'b0, mon_rdy}, 1);
    chk("rst_mid_error", {31'b0, mon_err}, {31'b0, m_e});
    jtag_cmd(1, 0, 0, 0, 0);

    repeat (6) @(posedge clk);
    chk("jtag_queue_drained", jq.size(), 0);
    chk("cpu_queue_drained", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
